// File: rtl/uart_prog_pkg.sv
// Shared types and helpers for the UART instruction-memory loader.
package uart_prog_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_t;

    // Byte lane inside a 32-bit instruction word, lane 0 = bits 7:0.
    typedef logic [1:0] lane_idx_t;

    localparam lane_idx_t LaneLast = 2'd3;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: rx synchronizer, baud counter and framing state machine.
module uart_rx_byte
    import uart_prog_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    logic            rx_meta_q, rx_sync_q;
    rx_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            sample_point;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_sync_q) state_d = StStart;
            end
            StStart: begin
                // Re-check mid start bit so short low glitches are ignored.
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sample_point = (state_q == StStop) && (cnt_q == BitLast);
        byte_valid   = sample_point && rx_sync_q;
        frame_err    = sample_point && !rx_sync_q;
    end

    assign byte_data = shift_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Packs UART bytes LSB-first into 32-bit words and writes them to instruction memory.
module uart_imem_loader
    import uart_prog_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned IMEM_AW  = 12
) (
    input  logic               clk,
    input  logic               Rst,
    input  logic               prog,
    input  logic               rx,
    output logic               memcon_prog_ena,
    output logic               prog_we,
    output logic [IMEM_AW-1:0] prog_addr,
    output logic [31:0]        uart_dout,
    output logic [IMEM_AW:0]   word_count,
    output logic               frame_err
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [IMEM_AW:0] CountMax = {1'b1, {IMEM_AW{1'b0}}};

    logic               rx_valid, rx_ferr;
    logic [7:0]         rx_data;
    logic               ena_q, we_q, ferr_q;
    lane_idx_t          byte_idx_q;
    logic [23:0]        lanes_q;
    logic [31:0]        dout_q;
    logic [IMEM_AW-1:0] waddr_q, addr_q;
    logic [IMEM_AW:0]   count_q;
    logic               prog_rise, take;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .Rst       (Rst),
        .rx        (rx),
        .byte_valid(rx_valid),
        .byte_data (rx_data),
        .frame_err (rx_ferr)
    );

    assign prog_rise = prog & ~ena_q;
    assign take      = ena_q & rx_valid;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            ena_q      <= 1'b0;
            we_q       <= 1'b0;
            ferr_q     <= 1'b0;
            byte_idx_q <= '0;
            lanes_q    <= '0;
            dout_q     <= '0;
            waddr_q    <= '0;
            addr_q     <= '0;
            count_q    <= '0;
        end else begin
            ena_q  <= prog;
            ferr_q <= rx_ferr;
            we_q   <= take && (byte_idx_q == LaneLast);
            if (prog_rise) begin
                byte_idx_q <= '0;
                waddr_q    <= '0;
                count_q    <= '0;
            end else begin
                if (take) begin
                    byte_idx_q <= byte_idx_q + 1'b1;
                    unique case (byte_idx_q)
                        2'd0: lanes_q[7:0]   <= rx_data;
                        2'd1: lanes_q[15:8]  <= rx_data;
                        2'd2: lanes_q[23:16] <= rx_data;
                        LaneLast: begin
                            dout_q <= {rx_data, lanes_q};
                            addr_q <= waddr_q;
                            if (count_q != CountMax) count_q <= count_q + 1'b1;
                        end
                        default: ;
                    endcase
                end
                // prog_addr is a separate register so it holds across this bump.
                if (we_q) waddr_q <= waddr_q + 1'b1;
            end
        end
    end

    assign memcon_prog_ena = ena_q;
    assign prog_we         = we_q;
    assign prog_addr       = addr_q;
    assign uart_dout       = dout_q;
    assign word_count      = count_q;
    assign frame_err       = ferr_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader at 16 clocks per bit, 16-word memory.
module tb_uart_imem_loader;

    localparam int unsigned Cpb = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog;
    logic        rx;
    logic        memcon_prog_ena;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [31:0] uart_dout;
    logic [4:0]  word_count;
    logic        frame_err;

    int n_pass  = 0;
    int n_total = 0;
    int we_cnt  = 0;
    int ferr_cnt = 0;
    logic [31:0] cap_dout [0:127];
    logic [3:0]  cap_addr [0:127];
    int base_we, base_fe;

    uart_imem_loader #(
        .CLK_FREQ(16),
        .BAUD    (1),
        .IMEM_AW (4)
    ) dut (
        .clk            (clk),
        .Rst            (rst),
        .prog           (prog),
        .rx             (rx),
        .memcon_prog_ena(memcon_prog_ena),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .uart_dout      (uart_dout),
        .word_count     (word_count),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prog_we) begin
            if (we_cnt < 128) begin
                cap_dout[we_cnt] = uart_dout;
                cap_addr[we_cnt] = prog_addr;
            end
            we_cnt = we_cnt + 1;
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        wait_clks(Cpb);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(Cpb);
        end
        rx = stop;
        wait_clks(Cpb);
        rx = 1'b1;
        wait_clks(2);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic restart_prog();
        prog = 1'b0;
        wait_clks(3);
        prog = 1'b1;
        wait_clks(3);
    endtask

    initial begin
        rst  = 1'b1;
        prog = 1'b0;
        rx   = 1'b1;
        wait_clks(3);
        check("rst_we", {31'd0, prog_we}, 32'd0);
        check("rst_addr", {28'd0, prog_addr}, 32'd0);
        check("rst_dout", uart_dout, 32'd0);
        check("rst_count", {27'd0, word_count}, 32'd0);
        check("rst_ena", {31'd0, memcon_prog_ena}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        wait_clks(2);

        // memcon_prog_ena follows prog one clock later
        prog = 1'b1;
        #1 check("ena_lag0", {31'd0, memcon_prog_ena}, 32'd0);
        wait_clks(1);
        check("ena_lag1", {31'd0, memcon_prog_ena}, 32'd1);
        wait_clks(2);

        // basic word
        base_we = we_cnt;
        send_word(32'h0000_0013);
        wait_clks(4);
        check("basic_nwe", we_cnt - base_we, 32'd1);
        check("basic_dout", cap_dout[base_we], 32'h0000_0013);
        check("basic_addr", {28'd0, cap_addr[base_we]}, 32'd0);
        check("basic_count", {27'd0, word_count}, 32'd1);
        check("basic_hold", uart_dout, 32'h0000_0013);

        // two consecutive words from a fresh start
        restart_prog();
        base_we = we_cnt;
        send_word(32'h0010_0093);
        send_word(32'h0020_0113);
        wait_clks(4);
        check("consec_nwe", we_cnt - base_we, 32'd2);
        check("consec_dout0", cap_dout[base_we], 32'h0010_0093);
        check("consec_addr0", {28'd0, cap_addr[base_we]}, 32'd0);
        check("consec_dout1", cap_dout[base_we+1], 32'h0020_0113);
        check("consec_addr1", {28'd0, cap_addr[base_we+1]}, 32'd1);
        check("consec_count", {27'd0, word_count}, 32'd2);

        // 17 words: address wraps, count saturates
        restart_prog();
        base_we = we_cnt;
        for (int w = 1; w <= 17; w++) send_word({4{w[7:0]}});
        wait_clks(4);
        check("wrap_nwe", we_cnt - base_we, 32'd17);
        check("wrap_addr15", {28'd0, cap_addr[base_we+15]}, 32'd15);
        check("wrap_addr16", {28'd0, cap_addr[base_we+16]}, 32'd0);
        check("wrap_dout16", cap_dout[base_we+16], 32'h1111_1111);
        check("wrap_count", {27'd0, word_count}, 32'd16);

        // bad stop bit, then a 4-clock glitch; neither may fill a lane
        restart_prog();
        base_we = we_cnt;
        base_fe = ferr_cnt;
        send_byte(8'h55, 1'b0);
        wait_clks(16);
        check("ferr_pulse", ferr_cnt - base_fe, 32'd1);
        check("ferr_nwe", we_cnt - base_we, 32'd0);
        rx = 1'b0;
        wait_clks(4);
        rx = 1'b1;
        wait_clks(32);
        check("glitch_ferr", ferr_cnt - base_fe, 32'd1);
        send_word(32'hDDCC_BBAA);
        wait_clks(4);
        check("ferr_after_nwe", we_cnt - base_we, 32'd1);
        check("ferr_after_dout", cap_dout[base_we], 32'hDDCC_BBAA);
        check("ferr_after_addr", {28'd0, cap_addr[base_we]}, 32'd0);

        // partial word dropped by a prog toggle
        restart_prog();
        base_we = we_cnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        restart_prog();
        send_word(32'h7766_5544);
        wait_clks(4);
        check("mode_nwe", we_cnt - base_we, 32'd1);
        check("mode_dout", cap_dout[base_we], 32'h7766_5544);
        check("mode_addr", {28'd0, cap_addr[base_we]}, 32'd0);
        check("mode_count", {27'd0, word_count}, 32'd1);

        // bytes with prog low are ignored
        prog = 1'b0;
        wait_clks(3);
        base_we = we_cnt;
        send_word(32'h0102_0304);
        wait_clks(4);
        check("noprog_nwe", we_cnt - base_we, 32'd0);
        check("noprog_ena", {31'd0, memcon_prog_ena}, 32'd0);

        // reset during data bit 3
        prog = 1'b1;
        wait_clks(3);
        send_word(32'hCAFE_F00D);
        wait_clks(4);
        check("prerst_dout", uart_dout, 32'hCAFE_F00D);
        rx = 1'b0;
        wait_clks(Cpb);
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            wait_clks(Cpb);
        end
        rx = 1'b1;
        wait_clks(8);
        rst = 1'b1;
        #1;
        check("midrst_dout", uart_dout, 32'd0);
        check("midrst_count", {27'd0, word_count}, 32'd0);
        check("midrst_addr", {28'd0, prog_addr}, 32'd0);
        check("midrst_ena", {31'd0, memcon_prog_ena}, 32'd0);
        check("midrst_we", {31'd0, prog_we}, 32'd0);
        wait_clks(3);
        rst = 1'b0;
        wait_clks(3);
        base_we = we_cnt;
        send_word(32'h0403_0201);
        wait_clks(4);
        check("postrst_nwe", we_cnt - base_we, 32'd1);
        check("postrst_dout", cap_dout[base_we], 32'h0403_0201);
        check("postrst_addr", {28'd0, cap_addr[base_we]}, 32'd0);
        check("postrst_count", {27'd0, word_count}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
